// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: execute-stage NZCV flags, condition gating and wrong-path squash sequencer.
// Optional macro COND_ILLEGAL_TRAP_EN makes illegal condition codes set a sticky CondErr.
module cond_exec_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Stall,
  input  logic       ValidE,
  input  logic [3:0] CondE,
  input  logic       FlagWriteE,
  input  logic [3:0] ALUFlags,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  input  logic       CondErrClr,
  output logic       RegWriteG,
  output logic       MemWriteG,
  output logic       BranchTaken,
  output logic       FlushD,
  output logic [3:0] Flags,
  output logic       CondErr
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic       n, z, v, ge, cond_ex, squash, live, illegal;
  assign {n, z, v} = {Flags[3], Flags[2], Flags[0]};
  assign ge = (n == v);
  assign illegal = (CondE > 4'd6);
  assign cond_ex = (CondE == 4'd0) ? z :
                   (CondE == 4'd1) ? ~z :
                   (CondE == 4'd2) ? ge :
                   (CondE == 4'd3) ? ~ge :
                   (CondE == 4'd4) ? (~z & ge) :
                   (CondE == 4'd5) ? ~(~z & ge) :
                   (CondE == 4'd6);
  assign squash = (state == FLUSH);
  assign live = ValidE & ~squash & cond_ex;
  assign RegWriteG = live & RegWriteE;
  assign MemWriteG = live & MemWriteE;
  assign BranchTaken = live & BranchE;
  assign FlushD = BranchTaken | (squash & (cnt != 3'd0));
  // Branches seen while squashing are themselves squashed, so only IDLE can start a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      Flags <= 4'd0;
    end else if (!Stall) begin
      if (live && FlagWriteE) Flags <= ALUFlags;
      if (state == IDLE) begin
        if (BranchTaken) begin
          state <= FLUSH;
          cnt   <= 3'(FLUSH_CYCLES - 1);
        end
      end else if (cnt == 3'd0) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end
`ifdef COND_ILLEGAL_TRAP_EN
  logic unused_c;
  assign unused_c = Flags[1];
  // A new error in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) CondErr <= 1'b0;
    else if (!Stall) CondErr <= (ValidE & ~squash & illegal) | (CondErr & ~CondErrClr);
  end
`else
  logic unused_c;
  assign unused_c = Flags[1] ^ CondErrClr ^ illegal;
  assign CondErr = 1'b0;
`endif
endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb_cond_exec_ctrl: directed and random checks of cond_exec_ctrl against a behavioural model.
module tb_cond_exec_ctrl;
  localparam int FC = 2;
  logic       clk = 1'b0, reset = 1'b0;
  logic       Stall = 1'b0, ValidE = 1'b0, FlagWriteE = 1'b0, RegWriteE = 1'b0;
  logic       MemWriteE = 1'b0, BranchE = 1'b0, CondErrClr = 1'b0;
  logic [3:0] CondE = 4'd0, ALUFlags = 4'd0;
  logic       RegWriteG, MemWriteG, BranchTaken, FlushD, CondErr;
  logic [3:0] Flags;
  int compared = 0, mismatched = 0;
  logic [3:0] m_flags = 4'd0;
  int         m_sq = 0;
  logic       m_err = 1'b0;
`ifdef COND_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  cond_exec_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .ValidE(ValidE), .CondE(CondE),
    .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .CondErrClr(CondErrClr),
    .RegWriteG(RegWriteG), .MemWriteG(MemWriteG), .BranchTaken(BranchTaken),
    .FlushD(FlushD), .Flags(Flags), .CondErr(CondErr));
  always #5 clk = ~clk;
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit z, ge;
    z = f[2];
    ge = (f[3] == f[0]);
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return ge;
      4'd3: return !ge;
      4'd4: return !z && ge;
      4'd5: return z || !ge;
      4'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag, input bit live);
    chk({tag, ".RegWriteG"}, {3'd0, RegWriteG}, {3'd0, live & RegWriteE});
    chk({tag, ".MemWriteG"}, {3'd0, MemWriteG}, {3'd0, live & MemWriteE});
    chk({tag, ".BranchTaken"}, {3'd0, BranchTaken}, {3'd0, live & BranchE});
    chk({tag, ".FlushD"}, {3'd0, FlushD}, {3'd0, (live & BranchE) | (m_sq > 1)});
    chk({tag, ".Flags"}, Flags, m_flags);
    chk({tag, ".CondErr"}, {3'd0, CondErr}, {3'd0, m_err});
  endtask
  // One E-cycle: drive at negedge, check mid-cycle, advance the model at the rising edge.
  task automatic cyc(input string tag, input bit v, input logic [3:0] c, input bit fw,
                     input logic [3:0] alu, input bit rw, input bit mw, input bit br,
                     input bit clr, input bit st);
    bit sq, live;
    {ValidE, CondE, FlagWriteE, ALUFlags, RegWriteE} = {v, c, fw, alu, rw};
    {MemWriteE, BranchE, CondErrClr, Stall} = {mw, br, clr, st};
    #2;
    sq = (m_sq > 0);
    live = v && !sq && cond_ok(c, m_flags);
    check_all(tag, live);
    @(posedge clk);
    if (!st) begin
      if (live && fw) m_flags = alu;
      if (TRAP) m_err = (v && !sq && c > 4'd6) || (m_err && !clr);
      if (m_sq > 0) m_sq--;
      else if (live && br) m_sq = FC;
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b0);
    reset = 1'b1;
    cyc("al_rw", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("eq_rw", 1, 4'd0, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("set_z", 1, 4'd6, 1, 4'b0100, 0, 0, 0, 0, 0);
    chk("flags_z", Flags, 4'b0100);
    cyc("eq_mw", 1, 4'd0, 0, 4'd0, 0, 1, 0, 0, 0);
    cyc("ne_mw", 1, 4'd1, 0, 4'd0, 0, 1, 0, 0, 0);
    cyc("set_n", 1, 4'd6, 1, 4'b1000, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++) cyc("n_cmp", 1, 4'(i), 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("set_nv", 1, 4'd6, 1, 4'b1001, 0, 0, 0, 0, 0);
    cyc("nv_ge", 1, 4'd2, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("nv_gt", 1, 4'd4, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("br", 1, 4'd6, 0, 4'd0, 0, 0, 1, 0, 0);
    cyc("sq1", 1, 4'd6, 1, 4'b1111, 1, 1, 0, 0, 0);
    chk("flags_held", Flags, 4'b1001);
    cyc("sq2", 1, 4'd6, 0, 4'd0, 1, 0, 1, 0, 0);
    cyc("post", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("br2", 1, 4'd6, 0, 4'd0, 0, 0, 1, 0, 0);
    cyc("sq_a", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("stall", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 1);
    cyc("sq_b", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("post2", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("br3", 1, 4'd6, 0, 4'd0, 0, 0, 1, 0, 0);
    cyc("sq_r", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    {ValidE, RegWriteE, BranchE, FlagWriteE} = 4'd0;
    reset = 1'b0;
    #2;
    m_flags = 4'd0; m_sq = 0; m_err = 1'b0;
    check_all("async_rst", 1'b0);
    reset = 1'b1;
    @(negedge clk);
    cyc("after_rst", 1, 4'd6, 0, 4'd0, 1, 0, 0, 0, 0);
    cyc("illegal", 1, 4'b1010, 0, 4'd0, 1, 0, 0, 0, 0);
    chk("err_set", {3'd0, CondErr}, {3'd0, TRAP});
    cyc("err_hold", 1, 4'd6, 0, 4'd0, 0, 0, 0, 0, 0);
    cyc("err_clr", 0, 4'd6, 0, 4'd0, 0, 0, 0, 1, 0);
    cyc("err_clred", 0, 4'd6, 0, 4'd0, 0, 0, 0, 0, 0);
    cyc("ill_set", 1, 4'd9, 0, 4'd0, 0, 0, 0, 0, 0);
    cyc("set_wins", 1, 4'd15, 0, 4'd0, 0, 0, 0, 1, 0);
    cyc("chk_wins", 0, 4'd6, 0, 4'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc("rand", $urandom_range(0, 5) != 0, 4'($urandom_range(0, 8)), $urandom_range(0, 2) == 0,
          4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
